// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the four digit patterns of a multiplexed
// seven-segment display from the active-low anode/segment buses. A dwell
// is accepted once its sample has been seen SETTLE times in a row. Legal
// dwells update one digit lane. Illegal anode patterns bump a saturating
// error count. A one-cycle frame_done pulse marks each completed set of
// four distinct digits.

// One digit lane: holds the captured pattern and its valid flag.
module seg_scan_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic       clr,
  input  logic [7:0] pat,
  output logic [7:0] digit,
  output logic       valid
);

  logic [7:0] digit_q, digit_d;
  logic       valid_q, valid_d;

  // next lane state: clear beats a capture landing on the same edge
  always_comb begin
    digit_d = digit_q;
    valid_d = valid_q;
    if (clr) begin
      digit_d = 8'h00;
      valid_d = 1'b0;
    end else if (cap) begin
      digit_d = pat;
      valid_d = 1'b1;
    end
  end

  // lane registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      digit_q <= digit_d;
      valid_q <= valid_d;
    end
  end

  assign digit = digit_q;
  assign valid = valid_q;

endmodule

module seg_scan_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam int         NUM_DIG   = 4;
  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  // sample register {an,seg}; idles at "all off"
  logic [11:0] samp_q, samp_d;
  // dwell length of the held sample, saturating at SETTLE
  logic [3:0]  cnt_q, cnt_d;
  // high for the single cycle in which cnt first sits at SETTLE
  logic        acc_q, acc_d;
  // digits captured in the current frame
  logic [3:0]  seen_q, seen_d;
  logic        fd_q, fd_d;
  logic [7:0]  err_q, err_d;

  logic [3:0]  an_act;
  logic        one_hot;
  logic        blank;
  logic [3:0]  cap_vec;
  logic        illegal;
  logic [7:0]  pat;
  logic [NUM_DIG-1:0][7:0] dig_arr;

  // sampling and dwell counting; accept fires on the SETTLE-1 -> SETTLE step
  // only, so a long dwell produces exactly one accept
  always_comb begin
    samp_d = {an, seg};
    if (samp_d != samp_q)
      cnt_d = 4'd1;
    else if (cnt_q == SETTLE_C)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 4'd1;
    acc_d = (cnt_d == SETTLE_C) && (cnt_q == SETTLE_M1);
  end

  // anode decode of the accepted (held) sample
  always_comb begin
    an_act  = ~samp_q[11:8];
    blank   = (an_act == 4'b0000);
    one_hot = !blank && ((an_act & (an_act - 4'd1)) == 4'b0000);
    cap_vec = (acc_q && one_hot) ? an_act : 4'b0000;
    illegal = acc_q && !one_hot && !blank;
    pat     = ~samp_q[7:0];
  end

  // frame tracking and error count; a full seen set is reported one edge
  // later and wiped on that edge, so a capture on that edge opens the next
  // frame
  always_comb begin
    seen_d = (seen_q == 4'b1111) ? 4'b0000 : seen_q;
    seen_d = seen_d | cap_vec;
    fd_d   = (seen_q == 4'b1111);
    err_d  = err_q;
    if (illegal && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
    if (clear) begin
      seen_d = 4'b0000;
      fd_d   = 1'b0;
      err_d  = 8'h00;
    end
  end

  // capture-path registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= 12'hFFF;
      cnt_q  <= 4'd0;
      acc_q  <= 1'b0;
      seen_q <= 4'b0000;
      fd_q   <= 1'b0;
      err_q  <= 8'h00;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      seen_q <= seen_d;
      fd_q   <= fd_d;
      err_q  <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_lane
    seg_scan_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .cap   (cap_vec[i]),
      .clr   (clear),
      .pat   (pat),
      .digit (dig_arr[i]),
      .valid (digit_valid[i])
    );
  end

  assign digits     = dig_arr;
  assign frame_done = fd_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed test-plan scenarios plus random scans,
// tracked against a run-length reference model of the display receiver.
module tb_seg_scan_capture;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        clear;
  logic [31:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  seg_scan_capture #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .clear(clear),
    .digits(digits), .digit_valid(digit_valid),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  m_dig [4];
  logic [3:0]  m_val, m_seen;
  logic        m_fd, m_fdp, m_acc;
  int          m_err, m_run, m_fd_cnt;
  logic [11:0] m_last, m_acc_v;
  // cycle trace bookkeeping
  int          mm = 0;
  int          dut_fd = 0;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 8'h00;
    m_val = 0; m_seen = 0; m_fd = 0; m_fdp = 0; m_acc = 0;
    m_err = 0; m_run = 0; m_last = 12'hFFF; m_acc_v = 12'hFFF;
  endfunction

  function automatic logic [44:0] m_pack();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_val, m_fd, 8'(m_err)};
  endfunction

  // one clock edge of the model: effects of last cycle's accept first,
  // then the new sample extends or restarts the run
  function automatic void m_edge(input logic [3:0] a, input logic [7:0] s,
                                 input logic c);
    logic [11:0] v;
    int nz, idx;
    v = {a, s};
    if (c) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 8'h00;
      m_val = 0; m_seen = 0; m_fd = 0; m_err = 0;
    end else begin
      m_fd = m_fdp;
      if (m_fdp) m_seen = 0;
      if (m_acc) begin
        nz = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!m_acc_v[8+i]) begin nz++; idx = i; end
        if (nz == 1) begin
          m_dig[idx] = ~m_acc_v[7:0];
          m_val[idx] = 1'b1;
          m_seen[idx] = 1'b1;
        end else if (nz > 1) begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
      end
    end
    m_fdp = (m_seen == 4'hF);
    if (m_fd) m_fd_cnt++;
    if (v == m_last) m_run++;
    else begin m_run = 1; m_last = v; end
    m_acc = (m_run == SETTLE);
    m_acc_v = v;
  endfunction

  // drive one cycle, advance the model, and trace any divergence
  task automatic drive(input logic [3:0] a, input logic [7:0] s, input logic c);
    an = a; seg = s; clear = c;
    @(posedge clk);
    #1;
    m_edge(a, s, c);
    if (frame_done) dut_fd++;
    if ({digits, digit_valid, frame_done, err_cnt} !== m_pack()) mm++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) drive(a, s, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; an = 4'hF; seg = 8'hFF; clear = 1'b0;
    m_fd_cnt = 0;
    m_reset();
    #12;
    checks++;
    if ({digits, digit_valid, frame_done, err_cnt} !== 45'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", {digits, digit_valid, frame_done, err_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_legal_scan();
    int mm0, fd0;
    mm0 = mm; fd0 = dut_fd;
    dwell(4'b1110, 8'hC0, 8);
    dwell(4'b1101, 8'hF9, 8);
    dwell(4'b1011, 8'hA4, 8);
    dwell(4'b0111, 8'hB0, 8);
    checks++;
    if (digits !== 32'h4F5B063F) begin
      errors++; $display("FAIL legal_digits got %h exp 4f5b063f", digits);
    end
    checks++;
    if (digit_valid !== 4'hF || err_cnt !== 8'd0) begin
      errors++; $display("FAIL legal_valid_err got %b/%0d exp 1111/0", digit_valid, err_cnt);
    end
    checks++;
    if (dut_fd - fd0 != 1) begin
      errors++; $display("FAIL legal_frame_pulses got %0d exp 1", dut_fd - fd0);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL legal_trace got %0d diverging cycles exp 0", mm - mm0);
    end
  endtask

  task automatic test_glitch();
    int fd0;
    drive(4'hF, 8'hFF, 1'b1);
    fd0 = dut_fd;
    dwell(4'b1110, 8'h80, 3);
    dwell(4'b1111, 8'hFF, 6);
    checks++;
    if (digits !== 32'd0 || digit_valid !== 4'b0000 || dut_fd != fd0) begin
      errors++;
      $display("FAIL glitch_reject got %h/%b/%0d exp 0/0000/0", digits, digit_valid, dut_fd - fd0);
    end
    dwell(4'b1110, 8'h80, 4);
    checks++;
    if (digit_valid[0] !== 1'b0) begin
      errors++; $display("FAIL settle_early got valid0=%b exp 0", digit_valid[0]);
    end
    drive(4'hF, 8'hFF, 1'b0);
    checks++;
    if (digits[7:0] !== 8'h7F || digit_valid !== 4'b0001) begin
      errors++; $display("FAIL settle_capture got %h/%b exp 7f/0001", digits[7:0], digit_valid);
    end
    dwell(4'hF, 8'hFF, 3);
  endtask

  task automatic test_illegal();
    logic [3:0] a;
    int nz, mm0;
    mm0 = mm;
    dwell(4'b1100, 8'($urandom), 10);
    dwell(4'hF, 8'hFF, 4);
    checks++;
    if (err_cnt !== 8'd1 || digits !== 32'h0000007F) begin
      errors++; $display("FAIL illegal_one got err=%0d dig=%h exp 1/0000007f", err_cnt, digits);
    end
    for (int k = 0; k < 300; k++) begin
      do begin
        a = 4'($urandom);
        nz = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) nz++;
      end while (nz < 2);
      dwell(a, 8'($urandom), SETTLE);
      dwell(4'hF, 8'hFF, SETTLE);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL illegal_saturate got %0d exp 255", err_cnt);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL illegal_trace got %0d diverging cycles exp 0", mm - mm0);
    end
  endtask

  task automatic test_blank_repeat();
    logic [7:0] s0, s1, s2;
    int fd0;
    drive(4'hF, 8'hFF, 1'b1);
    fd0 = dut_fd;
    s0 = 8'($urandom);
    s1 = s0 ^ 8'h5A;
    s2 = s1 ^ 8'h0F;
    dwell(4'hF, 8'hFF, 20);
    dwell(4'b1110, s0, 6);
    dwell(4'b1110, s1, 6);
    dwell(4'b1110, s2, 6);
    dwell(4'hF, 8'hFF, 4);
    checks++;
    if (err_cnt !== 8'd0 || dut_fd != fd0) begin
      errors++; $display("FAIL blank_quiet got err=%0d fd=%0d exp 0/0", err_cnt, dut_fd - fd0);
    end
    checks++;
    if (digits[7:0] !== ~s2 || digit_valid !== 4'b0001) begin
      errors++; $display("FAIL repeat_last got %h/%b exp %h/0001", digits[7:0], digit_valid, ~s2);
    end
  endtask

  task automatic test_clear_coincident();
    int fd0, mm0;
    mm0 = mm;
    drive(4'hF, 8'hFF, 1'b1);
    fd0 = dut_fd;
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 6);
    dwell(4'b1011, 8'hA4, 4);
    drive(4'b1011, 8'hA4, 1'b1);
    checks++;
    if (digits !== 32'd0 || digit_valid !== 4'b0000) begin
      errors++; $display("FAIL clear_wins got %h/%b exp 0/0000", digits, digit_valid);
    end
    dwell(4'b0111, 8'hB0, 6);
    dwell(4'hF, 8'hFF, 3);
    checks++;
    if (dut_fd != fd0) begin
      errors++; $display("FAIL clear_no_frame got %0d pulses exp 0", dut_fd - fd0);
    end
    dwell(4'b1110, 8'h92, 6);
    dwell(4'b1101, 8'h82, 6);
    dwell(4'b1011, 8'hF8, 6);
    dwell(4'hF, 8'hFF, 3);
    checks++;
    if (dut_fd - fd0 != 1 || mm != mm0) begin
      errors++; $display("FAIL clear_rescan got %0d pulses %0d diverging exp 1/0", dut_fd - fd0, mm - mm0);
    end
  endtask

  task automatic test_reset_mid();
    int fd0;
    drive(4'hF, 8'hFF, 1'b1);
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 6);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({digits, digit_valid, frame_done, err_cnt} !== 45'd0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {digits, digit_valid, frame_done, err_cnt});
    end
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    fd0 = dut_fd;
    dwell(4'b1011, 8'hA4, 6);
    dwell(4'b0111, 8'hB0, 6);
    dwell(4'b1110, 8'h99, 6);
    dwell(4'hF, 8'hFF, 3);
    checks++;
    if (dut_fd != fd0 || digit_valid !== 4'b1101) begin
      errors++; $display("FAIL reset_partial got %0d pulses valid=%b exp 0/1101", dut_fd - fd0, digit_valid);
    end
    dwell(4'b1101, 8'h92, 6);
    dwell(4'hF, 8'hFF, 3);
    checks++;
    if (dut_fd - fd0 != 1) begin
      errors++; $display("FAIL reset_fresh_frame got %0d pulses exp 1", dut_fd - fd0);
    end
  endtask

  task automatic test_random();
    int mm0, fdm0, fd0, r, len;
    logic [3:0] a;
    mm0 = mm; fdm0 = m_fd_cnt; fd0 = dut_fd;
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) a = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 8) a = 4'hF;
      else a = 4'($urandom) & 4'b1100;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++)
        drive(a, (r < 8 && a == 4'hF) ? 8'hFF : 8'(k * 37 + 11),
              ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL random_trace got %0d diverging cycles exp 0", mm - mm0);
    end
    checks++;
    if (dut_fd - fd0 != m_fd_cnt - fdm0) begin
      errors++; $display("FAIL random_frames got %0d exp %0d", dut_fd - fd0, m_fd_cnt - fdm0);
    end
  endtask

  initial begin
    test_reset();
    test_legal_scan();
    test_glitch();
    test_illegal();
    test_blank_repeat();
    test_clear_coincident();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
